// File: rtl/pat_code_receiver.sv
// 8N1 UART receiver assembling SYNC + 4 payload bytes + XOR checksum into a 32-bit paddle code.
// Fetch/Frame_err pulse one clock after the checksum byte (or error) is seen; no backpressure, Rx is never stalled.
module pat_code_receiver #(
    parameter int          CLK_FREQ       = 100000000,
    parameter int          BAUD           = 9600,
    parameter logic [7:0]  SYNC_BYTE      = 8'h5A,
    parameter int          TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rx,
    output logic [31:0] Code,
    output logic        Fetch,
    output logic        Frame_err
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
    typedef enum logic [2:0] {F_WAIT_SYNC, F_P3, F_P2, F_P1, F_P0, F_CHK} frame_state_t;

    logic          rx_s1, rx_s2, rx_prev;
    bit_state_t    bstate, bstate_nxt;
    logic [CW-1:0] bcnt;
    logic [2:0]    bidx;
    logic [7:0]    shreg;
    logic          byte_valid, stop_err;
    logic          half_done, bit_done;

    frame_state_t  fstate, fstate_nxt;
    logic [31:0]   shadow;
    logic [TW-1:0] tcnt;
    logic          timeout, set_fetch, set_err;

    // ---------------- bit level ----------------
    always_comb begin
        bstate_nxt = bstate;
        half_done  = (bcnt == CW'(HALF - 1));
        bit_done   = (bcnt == CW'(CPB - 1));
        case (bstate)
            // Edge detect keeps a stuck-low line (after a stop error) from retriggering.
            B_IDLE:  if (rx_prev && !rx_s2) bstate_nxt = B_START;
            B_START: if (half_done) bstate_nxt = rx_s2 ? B_IDLE : B_DATA;
            B_DATA:  if (bit_done && bidx == 3'd7) bstate_nxt = B_STOP;
            B_STOP:  if (bit_done) bstate_nxt = B_IDLE;
            default: bstate_nxt = B_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            bstate     <= B_IDLE;
            bcnt       <= '0;
            bidx       <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            rx_s1      <= Rx;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            bstate     <= bstate_nxt;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
            case (bstate)
                B_IDLE: begin
                    bcnt <= '0;
                    bidx <= '0;
                end
                B_START: bcnt <= half_done ? '0 : bcnt + 1'b1;
                B_DATA: begin
                    if (bit_done) begin
                        bcnt  <= '0;
                        bidx  <= bidx + 1'b1;
                        shreg <= {rx_s2, shreg[7:1]};
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                B_STOP: begin
                    if (bit_done) begin
                        bcnt       <= '0;
                        byte_valid <= rx_s2;
                        stop_err   <= !rx_s2;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                default: bcnt <= '0;
            endcase
        end
    end

    // ---------------- frame level ----------------
    always_comb begin
        fstate_nxt = fstate;
        set_fetch  = 1'b0;
        set_err    = 1'b0;
        timeout    = (tcnt >= TW'(TIMEOUT_CYCLES - 1));
        if (byte_valid) begin
            case (fstate)
                F_WAIT_SYNC: if (shreg == SYNC_BYTE) fstate_nxt = F_P3;
                F_P3:        fstate_nxt = F_P2;
                F_P2:        fstate_nxt = F_P1;
                F_P1:        fstate_nxt = F_P0;
                F_P0:        fstate_nxt = F_CHK;
                F_CHK: begin
                    fstate_nxt = F_WAIT_SYNC;
                    if (shreg == (shadow[31:24] ^ shadow[23:16] ^ shadow[15:8] ^ shadow[7:0]))
                        set_fetch = 1'b1;
                    else
                        set_err = 1'b1;
                end
                default: fstate_nxt = F_WAIT_SYNC;
            endcase
        end else if (fstate != F_WAIT_SYNC && (stop_err || timeout)) begin
            fstate_nxt = F_WAIT_SYNC;
            set_err    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fstate    <= F_WAIT_SYNC;
            shadow    <= '0;
            tcnt      <= '0;
            Code      <= '0;
            Fetch     <= 1'b0;
            Frame_err <= 1'b0;
        end else begin
            fstate    <= fstate_nxt;
            Fetch     <= set_fetch;
            Frame_err <= set_err;
            if (fstate == F_WAIT_SYNC || byte_valid)
                tcnt <= '0;
            else if (!timeout)
                tcnt <= tcnt + 1'b1;
            if (byte_valid) begin
                case (fstate)
                    F_P3:    shadow[31:24] <= shreg;
                    F_P2:    shadow[23:16] <= shreg;
                    F_P1:    shadow[15:8]  <= shreg;
                    F_P0:    shadow[7:0]   <= shreg;
                    default: shadow        <= shadow;
                endcase
            end
            if (set_fetch)
                Code <= shadow;
        end
    end
endmodule

// File: tb/tb_pat_code_receiver.sv
// Randomised + directed bench: a byte-level protocol model feeds a strobe scoreboard drained by a monitor.
module tb_pat_code_receiver;
    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [31:0] code;
    logic        fetch, frame_err;

    pat_code_receiver #(
        .CLK_FREQ(1000), .BAUD(100), .SYNC_BYTE(8'h5A), .TIMEOUT_CYCLES(300)
    ) dut (
        .clk(clk), .rst(rst), .Rx(rx), .Code(code), .Fetch(fetch), .Frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_fetch;
        logic [31:0] code;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          pos = 0;        // 0: hunting sync, 1..4: payload bytes taken, 5: awaiting checksum
    logic [7:0]  pay[4];
    logic [31:0] exp_code = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_err();
        sb.push_back('{is_fetch: 1'b0, code: exp_code});
    endtask

    // Protocol reference: operates on whole received bytes, not on bit timing.
    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            if (pos != 0) push_err();
            pos = 0;
        end else if (pos == 0) begin
            if (b == 8'h5A) pos = 1;
        end else if (pos < 5) begin
            pay[pos-1] = b;
            pos++;
        end else begin
            if (b == (pay[0] ^ pay[1] ^ pay[2] ^ pay[3])) begin
                exp_code = {pay[0], pay[1], pay[2], pay[3]};
                sb.push_back('{is_fetch: 1'b1, code: exp_code});
            end else begin
                push_err();
            end
            pos = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        model_byte(b, stop_ok);
        fr = {stop_ok ? 1'b1 : 1'b0, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            tick(CPB);
        end
        if (!stop_ok) begin
            rx = 1'b1;
            tick(12);
        end
    endtask

    // Any idle this long after a mid-frame byte exceeds the 300-clock inter-byte limit.
    task automatic idle(input int n);
        if (n >= 250 && pos != 0) begin
            push_err();
            pos = 0;
        end
        rx = 1'b1;
        tick(n);
    endtask

    task automatic send6(input logic [7:0] a, b, c, d, e, f, input int gap);
        logic [7:0] l[6];
        l = '{a, b, c, d, e, f};
        for (int i = 0; i < 6; i++) begin
            send_byte(l[i], 1'b1);
            if (gap > 0) idle(gap);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && (fetch || frame_err)) begin
            check("strobe_exclusive", {31'b0, fetch & frame_err}, 32'h0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: fetch=%b frame_err=%b code=%h, none expected (t=%0t)",
                         fetch, frame_err, code, $time);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", {31'b0, fetch}, {31'b0, e.is_fetch});
                check("strobe_code", code, e.code);
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation exceeded 60000 cycles, still %0d strobes expected", sb.size());
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : stim
        int         kind, where;
        logic [7:0] fr[6];

        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        check("rst_code", code, 32'h0);
        check("rst_fetch", {31'b0, fetch}, 32'h0);
        check("rst_frame_err", {31'b0, frame_err}, 32'h0);
        rst = 1'b0;
        tick(5);

        send6(8'h5A, 8'hFF, 8'h00, 8'h00, 8'hF0, 8'h0F, 3);
        tick(5);
        check("good_frame_code", code, 32'hFF0000F0);

        send6(8'h5A, 8'hAA, 8'h00, 8'h00, 8'h0A, 8'h00, 2);
        tick(5);
        check("bad_chk_code_held", code, 32'hFF0000F0);

        rx = 1'b0;
        tick(3);
        idle(20);
        send6(8'h5A, 8'h0F, 8'h00, 8'h00, 8'hAA, 8'hA5, 0);
        tick(5);
        check("after_glitch_code", code, 32'h0F0000AA);

        send_byte(8'h5A, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h33, 1'b0);
        send6(8'h5A, 8'hA0, 8'h00, 8'h00, 8'hA0, 8'h00, 1);
        tick(5);
        check("after_stop_err_code", code, 32'hA00000A0);

        send_byte(8'h5A, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(400);
        send6(8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
        idle(10);
        check("after_timeout_code", code, 32'hA00000A0);

        // Reset while the P1 byte is on the wire.
        send_byte(8'h5A, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rx = 1'b0;
        tick(45);
        rst = 1'b1;
        rx  = 1'b1;
        tick(2);
        rst = 1'b0;
        pos = 0;
        exp_code = '0;
        tick(3);
        check("mid_frame_rst_code", code, 32'h0);
        check("mid_frame_rst_pending", sb.size(), 32'h0);
        send6(8'h5A, 8'h12, 8'h34, 8'h56, 8'h78, 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78, 0);
        send6(8'h5A, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, 0);
        idle(5);
        check("back_to_back_code", code, 32'hDEADBEEF);

        for (int it = 0; it < 25; it++) begin
            kind  = $urandom_range(0, 4);
            where = $urandom_range(1, 5);
            fr[0] = 8'h5A;
            for (int j = 1; j < 5; j++) fr[j] = 8'($urandom);
            fr[5] = fr[1] ^ fr[2] ^ fr[3] ^ fr[4];
            if (kind == 1) fr[5] = fr[5] ^ (8'h01 << $urandom_range(0, 7));
            if (kind == 2) send_byte(8'($urandom), 1'b1);
            for (int j = 0; j < 6; j++) begin
                send_byte(fr[j], !(kind == 3 && j == where));
                if (kind == 4 && j == where - 1) idle(400);
                else idle($urandom_range(0, 4));
            end
        end

        idle(400);
        check("scoreboard_drained", sb.size(), 32'h0);
        check("final_code", code, exp_code);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pat_code_receiver.md
Name: pat_code_receiver

Overview:
Serial front end of the paddle path. Receives 8N1 UART frames from the 52-series MCU motion sensor, assembles a 32-bit paddle code (Y half in [31:16], X half in [15:0]), verifies an XOR checksum, and presents Code with a one-cycle Fetch strobe to the downstream paddle decoder. It is the only producer of Code/Fetch.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 9600, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), must be >= 4
SYNC_BYTE, 8'h5A, frame header byte
TIMEOUT_CYCLES, 2000000, max clocks allowed between consecutive bytes inside a frame

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
Rx  input  1  asynchronous UART line from MCU, idle high
Code  output  32  last valid paddle code, held between frames
Fetch  output  1  one-cycle strobe, Code is new and valid
Frame_err  output  1  one-cycle strobe, frame dropped (checksum, stop bit, timeout)

Behaviour:
- One clock; reset is synchronous and active-high on rst. Reset values: Code=32'h0, Fetch=0, Frame_err=0, both FSMs idle, synchroniser flops=1, counters=0.
- Rx passes through a 2-flop synchroniser; all decisions use the synchronised value.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: falling edge (sync Rx=0) -> START, bit counter cleared.
  - START: at CLKS_PER_BIT/2 clocks sample; 1 -> IDLE (glitch, no error); 0 -> DATA.
  - DATA: sample every CLKS_PER_BIT clocks from start midpoint; 8 bits, LSB first.
  - STOP: sample one bit later; 1 -> byte_valid pulse (internal, 1 cycle), IDLE; 0 -> stop error (byte discarded, Frame_err pulse if frame FSM is past WAIT_SYNC), IDLE without waiting for line high. Next start requires a new falling edge.
- Frame FSM states: WAIT_SYNC, P3, P2, P1, P0, CHK; advances only on byte_valid.
  - WAIT_SYNC: byte==SYNC_BYTE -> P3; anything else ignored silently.
  - P3..P0: byte captured into shadow[31:24], [23:16], [15:8], [7:0] respectively (MSB first). SYNC_BYTE value inside payload is data, no resync.
  - CHK: byte compared with shadow[31:24]^shadow[23:16]^shadow[15:8]^shadow[7:0]. Match: Code<=shadow and Fetch=1 on the same next edge, -> WAIT_SYNC. Mismatch: Code unchanged, Frame_err=1, -> WAIT_SYNC.
  - Fetch asserts exactly 1 clock after the cycle byte_valid is raised for the checksum byte; Fetch and Frame_err never high together.
- Timeout: counter cleared on every byte_valid and in WAIT_SYNC; in P3..CHK, reaching TIMEOUT_CYCLES -> Frame_err pulse, -> WAIT_SYNC, shadow discarded. A byte in flight at that moment is then treated as a WAIT_SYNC candidate.
- Stop error in P3..CHK aborts the frame -> WAIT_SYNC.
- Code changes only on a passing checksum; Fetch never repeats without a new full frame.
- rst mid-byte or mid-frame: everything returns to reset values next edge; partial frame lost, no strobes.
- Back-to-back frames with zero idle gap (next start bit immediately after stop) must both be accepted.

Test Plan:
(Sim with CLK_FREQ=1000, BAUD=100 -> 10 clk/bit, TIMEOUT_CYCLES=300.)
- Bytes 5A FF 00 00 F0 0F -> Code=32'hFF0000F0, Fetch high 1 cycle, Frame_err stays 0.
- Bytes 5A AA 00 00 0A 00 (bad chk, expected A0) -> Frame_err 1 cycle, Code keeps previous FF0000F0, no Fetch.
- Rx low pulse of 3 clocks, then bytes 5A 0F 00 00 AA A5 -> glitch ignored, Code=32'h0F0000AA, one Fetch.
- 5A F0 00 then byte with stop bit 0 -> Frame_err 1 cycle; following good frame 5A A0 00 00 A0 00 -> Code=32'hA00000A0.
- 5A FF then 400 idle clocks -> Frame_err at 300 clocks after FF byte_valid; late bytes 00 00 FF 00 produce no Fetch.
- rst pulsed during P1 of a frame -> Code=0, no strobes; two back-to-back good frames afterwards -> two Fetch pulses, Code equals second payload.
